// File: rtl/svn_scan_ctrl.sv
// svn_scan_ctrl: time-multiplexed hex display scanner.
// Drives one shared seven-segment decoder and an active-low anode bus. Each
// digit slot starts with a blanking interval, then lights one anode. Display
// data is double-buffered and swapped only at the end of a full scan frame.
module svn_scan_ctrl #(
   parameter int N_DIG     = 8,
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic               clk,
   input  logic               sys_rst,
   input  logic               en,
   input  logic               wr_en,
   input  logic [4*N_DIG-1:0] wr_data,
   input  logic [N_DIG-1:0]   dp_in,
   input  logic [N_DIG-1:0]   dig_en,
   input  logic               lz_sup,
   output logic [3:0]         hex_out,
   output logic               dp_n,
   output logic [N_DIG-1:0]   AN,
   output logic               frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [N_DIG-1:0]   an_sel;
   logic [4*N_DIG-1:0] pend_data, act_data, act_data_nxt;
   logic [N_DIG-1:0]   pend_dp, act_dp, act_dp_nxt;
   logic               pend;

   logic               slot_end, blank_end, last_dig, boundary, upper_zero;
   logic [IW-1:0]      idx_nxt;
   logic [N_DIG-1:0]   show_an;

   // Slot/frame decode, next active buffer and the anode pattern for this slot
   always_comb begin
      slot_end  = (cnt == CW'(DIV - 1));
      blank_end = (cnt == CW'(BLANK_CYC - 1));
      last_dig  = (idx == IW'(N_DIG - 1));
      boundary  = en && slot_end && last_dig;
      idx_nxt   = idx;
      if (slot_end)
         idx_nxt = last_dig ? '0 : idx + IW'(1);

      // A write landing on the boundary bypasses the pending buffer
      act_data_nxt = act_data;
      act_dp_nxt   = act_dp;
      if (boundary) begin
         if (wr_en) begin
            act_data_nxt = wr_data;
            act_dp_nxt   = dp_in;
         end else if (pend) begin
            act_data_nxt = pend_data;
            act_dp_nxt   = pend_dp;
         end
      end

      upper_zero = 1'b1;
      for (int unsigned i = 0; i < N_DIG; i++) begin
         if ((IW'(i) >= idx) && (act_data[4*i +: 4] != 4'h0))
            upper_zero = 1'b0;
      end

      show_an = '1;
      if (dig_en[idx] && !(lz_sup && (idx != '0) && upper_zero))
         show_an = ~(N_DIG'(1) << idx);
   end

   // Prescaler, digit index, blank/show FSM, buffers and registered outputs
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= '0;
         an_sel     <= '1;
         AN         <= '1;
         hex_out    <= '0;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
         pend       <= 1'b0;
         pend_data  <= '0;
         pend_dp    <= '0;
         act_data   <= '0;
         act_dp     <= '0;
      end else begin
         frame_done <= boundary;
         act_data   <= act_data_nxt;
         act_dp     <= act_dp_nxt;
         if (boundary) begin
            pend <= 1'b0;
         end else if (wr_en) begin
            pend      <= 1'b1;
            pend_data <= wr_data;
            pend_dp   <= dp_in;
         end

         if (!en) begin
            AN <= '1;
         end else if (slot_end) begin
            cnt     <= '0;
            idx     <= idx_nxt;
            state   <= BLANK;
            AN      <= '1;
            hex_out <= act_data_nxt[4*idx_nxt +: 4];
            dp_n    <= ~act_dp_nxt[idx_nxt];
         end else begin
            cnt <= cnt + CW'(1);
            if (blank_end) begin
               state  <= SHOW;
               AN     <= show_an;
               an_sel <= show_an;
            end else if (state == SHOW) begin
               // Re-drives the pattern latched at SHOW entry after a pause
               AN <= an_sel;
            end
         end
      end
   end

endmodule

// File: tb/tb_svn_scan_ctrl.sv
// tb_svn_scan_ctrl: directed self-checking bench for svn_scan_ctrl
// (N_DIG=8, DIV=10, BLANK_CYC=2, so one frame is 80 clock cycles).
module tb_svn_scan_ctrl;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        en;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [7:0]  dp_in;
   logic [7:0]  dig_en;
   logic        lz_sup;
   logic [3:0]  hex_out;
   logic        dp_n;
   logic [7:0]  AN;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   svn_scan_ctrl #(.N_DIG(8), .DIV(10), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .en         (en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .dp_in      (dp_in),
      .dig_en     (dig_en),
      .lz_sup     (lz_sup),
      .hex_out    (hex_out),
      .dp_n       (dp_n),
      .AN         (AN),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advances at least one cycle, then waits (bounded) for frame_done
   task automatic wait_fd();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 200);
      if (!frame_done) check("fd_timeout", 32'd0, 32'd1);
   endtask

   // Called at the frame_done cycle (slot 0, cnt 0); checks one whole frame
   // and returns at the next frame_done cycle. A write strobe armed by the
   // caller lasts exactly one cycle.
   task automatic check_frame(input logic [31:0] hx, input logic [7:0] dp, input logic [7:0] vis);
      logic [7:0] exp_an;
      logic       exp_dp;
      logic       exp_fd;
      for (int s = 0; s < 8; s++) begin
         for (int c = 0; c < 10; c++) begin
            exp_an = (c < 2 || !vis[s]) ? 8'hFF : ~(8'h01 << s);
            exp_dp = ~dp[s];
            exp_fd = (s == 0 && c == 0);
            check("an", AN, exp_an);
            check("hex", hex_out, hx[4*s +: 4]);
            check("dp_n", dp_n, exp_dp);
            check("fd", frame_done, exp_fd);
            @(negedge clk);
            wr_en = 1'b0;
         end
      end
      check("fd_period", frame_done, 1'b1);
   endtask

   initial begin
      int n;
      sys_rst = 1'b1;
      en      = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      dp_in   = '0;
      dig_en  = 8'hFF;
      lz_sup  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_an", AN, 8'hFF);
      check("rst_hex", hex_out, 4'h0);
      check("rst_dp", dp_n, 1'b1);
      check("rst_fd", frame_done, 1'b0);

      // Basic scan of 8765_4321 with DP on digit 0
      sys_rst = 1'b0;
      wr_en   = 1'b1;
      wr_data = 32'h8765_4321;
      dp_in   = 8'h01;
      @(negedge clk);
      wr_en = 1'b0;
      wait_fd();
      check_frame(32'h8765_4321, 8'h01, 8'hFF);

      // Pause mid-SHOW of slot 3 for 5 cycles
      repeat (35) @(negedge clk);
      check("pre_pause_an", AN, 8'hF7);
      en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("pause_an", AN, 8'hFF);
         check("pause_hex", hex_out, 4'h4);
         check("pause_fd", frame_done, 1'b0);
      end
      en = 1'b1;
      @(negedge clk);
      check("resume_an", AN, 8'hF7);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 200);
      check("resume_len", n, 44);

      // Digit 2 disabled
      dig_en = 8'hFB;
      check_frame(32'h8765_4321, 8'h01, 8'hFB);
      dig_en = 8'hFF;

      // Leading-zero suppression
      wr_en   = 1'b1;
      wr_data = 32'h0000_0120;
      dp_in   = 8'h00;
      check_frame(32'h8765_4321, 8'h01, 8'hFF);
      lz_sup = 1'b1;
      check_frame(32'h0000_0120, 8'h00, 8'h07);
      lz_sup = 1'b0;
      check_frame(32'h0000_0120, 8'h00, 8'hFF);

      // Write exactly in the boundary cycle, then one cycle later
      repeat (79) @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 32'hAAAA_AAAA;
      @(negedge clk);
      wr_en = 1'b0;
      check("bnd_fd", frame_done, 1'b1);
      check("bnd_hex", hex_out, 4'hA);
      wr_en   = 1'b1;
      wr_data = 32'h5555_5555;
      dp_in   = 8'hFF;
      check_frame(32'hAAAA_AAAA, 8'h00, 8'hFF);
      check_frame(32'h5555_5555, 8'hFF, 8'hFF);

      // Pending write followed by an asynchronous reset mid-SHOW
      wr_en   = 1'b1;
      wr_data = 32'h1234_1234;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_an", AN, 8'hFE);
      check("pre_rst_dp", dp_n, 1'b0);
      #2 sys_rst = 1'b1;
      #1;
      check("arst_an", AN, 8'hFF);
      check("arst_hex", hex_out, 4'h0);
      check("arst_dp", dp_n, 1'b1);
      check("arst_fd", frame_done, 1'b0);
      @(negedge clk);
      sys_rst = 1'b0;
      wait_fd();
      check_frame(32'h0000_0000, 8'h00, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
